// File: rtl/cache_arb_pkg.sv
// Shared types for the L1-to-LLC line arbiter.
// Optional round-robin tie break is enabled with CACHE_ARB_RR_EN.
package cache_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RECOVER
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    I,
    D
  } arb_owner_t;

endpackage

// File: rtl/cache_arb_grant.sv
// Combinational winner select between I-cache and D-cache requests.
// CACHE_ARB_RR_EN: ties alternate using last_owner; otherwise D wins.
module cache_arb_grant
  import cache_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
`ifdef CACHE_ARB_RR_EN
  input  arb_owner_t last_owner,
`endif
  output arb_owner_t winner
);

  arb_owner_t tie;

`ifdef CACHE_ARB_RR_EN
  assign tie = (last_owner == D) ? I : D;
`else
  assign tie = D;
`endif

  always_comb begin
    winner = NONE;
    unique case (1'b1)
      d_req && !i_req: winner = D;
      i_req && !d_req: winner = I;
      i_req && d_req:  winner = tie;
      default:         winner = NONE;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// One-at-a-time line arbiter between L1 I/D caches and the LLC adaptor.
// Define CACHE_ARB_RR_EN for round-robin tie breaking.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_address_i,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [LINE_W-1:0] mem_line_o,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_resp_i
);

  arb_state_t state;
  arb_owner_t winner;
  logic       d_req;

  assign d_req = d_read_i | d_write_i;

`ifdef CACHE_ARB_RR_EN
  logic       last_d;
  arb_owner_t last_owner;

  assign last_owner = last_d ? D : I;
`endif

  cache_arb_grant u_grant (
    .i_req      (i_read_i),
    .d_req      (d_req),
`ifdef CACHE_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .winner     (winner)
  );

  // Caches qualify the shared line with their own resp.
  assign i_line_o = mem_line_i;
  assign d_line_o = mem_line_i;
  assign i_resp_o = mem_resp_i & (state == BUSY_I);
  assign d_resp_o = mem_resp_i & (state == BUSY_D);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_address_o <= '0;
      mem_line_o    <= '0;
`ifdef CACHE_ARB_RR_EN
      last_d        <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (winner == D) begin
            state         <= BUSY_D;
            mem_address_o <= d_address_i;
            // A simultaneous read+write is served as the write-back.
            if (d_write_i) begin
              mem_write_o <= 1'b1;
              mem_line_o  <= d_line_i;
            end else begin
              mem_read_o  <= 1'b1;
            end
`ifdef CACHE_ARB_RR_EN
            last_d        <= 1'b1;
`endif
          end else if (winner == I) begin
            state         <= BUSY_I;
            mem_address_o <= i_address_i;
            mem_read_o    <= 1'b1;
`ifdef CACHE_ARB_RR_EN
            last_d        <= 1'b0;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp_i) begin
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            state       <= RECOVER;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
